// File: rtl/dpram_stream_reader_if.sv
// Stream interface for the DPRAM reader's output.
// Signals:
//   m_data  - beat payload
//   m_valid - beat present on m_data
//   m_last  - final beat of the current transfer
//   m_ready - downstream accepts the beat this cycle
// Modports: master (source side, used by the reader), slave (sink side).
interface dpram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/dpram_stream_reader.sv
// Read master for one port of a dual-port RAM with a registered read
// (1-cycle latency, no enable). Reads a contiguous window that wraps at
// the top of the address space and presents the words as a valid/ready
// stream with a last-beat marker.
// Ports:
//   sys_clk, sys_rst_n   - clock (also clocks the RAM port), async active-low reset
//   start, base_addr,    - transfer request; accepted only while idle
//   length
//   busy, done           - transfer in progress / one-cycle completion pulse
//   ram_addr, ram_we,    - RAM port (write enable tied low)
//   ram_dout
//   m                    - output stream (master modport)
module dpram_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    dpram_stream_reader_if.master m
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [LEN_WIDTH-1:0]  rd_remaining;
    logic [LEN_WIDTH-1:0]  tx_remaining;
    logic                  rd_pending;

    // Two-entry output buffer; buf0 is the oldest stored word.
    logic [DATA_WIDTH-1:0] buf0, buf1, buf0_n, buf1_n;
    logic [1:0]            occ, occ_n;

    logic                  accept;
    logic                  accept_zero;
    logic                  issue;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop;
    logic                  last_pop;
    logic                  cap_store;

    assign accept      = (state == IDLE) && start && (length != '0);
    assign accept_zero = (state == IDLE) && start && (length == '0);

    // Credit rule: stored words plus the read in flight never exceed the
    // buffer depth, so a capture always has a free slot.
    assign issue = (state == READ) && (rd_remaining != '0) &&
                   ((occ + {1'b0, rd_pending}) < 2'd2);

    // When the buffer is empty, the word arriving from the RAM is the head.
    // This bypass is what lets the first beat appear two cycles after start.
    assign head_valid = (occ != 2'd0) || rd_pending;
    assign head_data  = (occ != 2'd0) ? buf0 : ram_dout;
    assign pop        = head_valid && m.m_ready;
    assign last_pop   = pop && (tx_remaining == LEN_WIDTH'(1));

    assign m.m_valid = head_valid;
    assign m.m_data  = head_valid ? head_data : '0;
    assign m.m_last  = head_valid && (tx_remaining == LEN_WIDTH'(1));

    // Address is presented combinationally on issue and held otherwise.
    assign ram_addr = issue ? rd_addr : ram_addr_q;
    assign ram_we   = 1'b0;

    // Next state.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = READ;
            READ:    if (issue && (rd_remaining == LEN_WIDTH'(1))) state_n = DRAIN;
            DRAIN:   if (last_pop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Buffer update: remove the popped head, then append the captured word
    // unless it was consumed straight through the bypass.
    always_comb begin
        buf0_n    = buf0;
        buf1_n    = buf1;
        occ_n     = occ;
        cap_store = rd_pending && !(pop && (occ == 2'd0));
        if (pop && (occ != 2'd0)) begin
            buf0_n = buf1;
            occ_n  = occ - 2'd1;
        end
        if (cap_store) begin
            if (occ_n == 2'd0) buf0_n = ram_dout;
            else               buf1_n = ram_dout;
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            rd_addr      <= '0;
            ram_addr_q   <= '0;
            rd_remaining <= '0;
            tx_remaining <= '0;
            rd_pending   <= 1'b0;
            buf0         <= '0;
            buf1         <= '0;
            occ          <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state      <= state_n;
            ram_addr_q <= ram_addr;
            rd_pending <= issue;
            buf0       <= buf0_n;
            buf1       <= buf1_n;
            occ        <= occ_n;
            done       <= accept_zero || last_pop;

            if (accept) begin
                rd_addr      <= base_addr;
                rd_remaining <= length;
            end else if (issue) begin
                rd_addr      <= rd_addr + ADDR_WIDTH'(1);
                rd_remaining <= rd_remaining - LEN_WIDTH'(1);
            end

            if (accept)   tx_remaining <= length;
            else if (pop) tx_remaining <= tx_remaining - LEN_WIDTH'(1);

            if (accept)        busy <= 1'b1;
            else if (last_pop) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 13;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length    = '0;
    logic          busy, done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;

    dpram_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .m         (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM with registered read.
    logic [DW-1:0] mem [4096];
    always @(posedge sys_clk) ram_dout <= mem[ram_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Transfer-level model: an accepted start enqueues the whole expected
    // window; each accepted beat must be the queue front.
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         q[$];
    bit            exp_busy = 0;
    bit            exp_done = 0;
    bit            hold     = 0;
    logic [DW-1:0] hold_data;
    int            popped   = 0;
    int            cur_len  = 0;
    logic [AW-1:0] cur_base = '0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                chk("rst_valid", bus.m_valid, 0);
                chk("rst_last", bus.m_last, 0);
                chk("rst_data", bus.m_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_addr", ram_addr, 0);
                q.delete();
                exp_busy = 0;
                exp_done = 0;
                hold     = 0;
                popped   = 0;
                cur_len  = 0;
            end else begin
                bit acc, nd, nb;
                chk("busy", busy, exp_busy);
                chk("done", done, exp_done);
                chk("ram_we", ram_we, 0);
                if (hold) chk("stall_valid", bus.m_valid, 1);
                if (bus.m_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_beat", bus.m_valid, 0);
                    end else begin
                        chk("beat_data", bus.m_data, q[0].d);
                        chk("beat_last", bus.m_last, q[0].l);
                        if (hold) chk("stall_data", bus.m_data, hold_data);
                    end
                end
                if (exp_busy && popped > 0 && popped < cur_len) begin
                    logic [AW-1:0] ahead;
                    ahead = ram_addr - cur_base - AW'(popped);
                    chk("addr_ahead_le2", ahead <= 2, 1);
                end

                acc = start && !exp_busy;
                nd  = 0;
                nb  = exp_busy;
                if (bus.m_valid && bus.m_ready && q.size() != 0) begin
                    if (q[0].l) begin
                        nd = 1;
                        nb = 0;
                    end
                    void'(q.pop_front());
                    popped++;
                end
                hold      = bus.m_valid && !bus.m_ready;
                hold_data = bus.m_data;
                if (acc) begin
                    if (length == '0) begin
                        nd = 1;
                    end else begin
                        for (int i = 0; i < int'(length); i++)
                            q.push_back('{d: mem[AW'(int'(base_addr) + i)], l: (i == int'(length) - 1)});
                        nb       = 1;
                        popped   = 0;
                        cur_len  = int'(length);
                        cur_base = base_addr;
                    end
                end
                exp_busy = nb;
                exp_done = nd;
            end
        end
    end

    // Downstream ready: held high, or a fixed stall pattern when enabled.
    bit pat_en = 0;
    initial begin
        bit pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
        int pidx = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (pat_en) begin
                bus.m_ready = pat[pidx];
                pidx = (pidx + 1) % 12;
            end else begin
                bus.m_ready = 1'b1;
            end
        end
    end

    // Drives start for exactly one cycle; returns 1ns into the cycle after.
    task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] len);
        @(posedge sys_clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = len;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((exp_busy || exp_done || q.size() != 0) && n < max) begin
            @(negedge sys_clk);
            #2;
            n++;
        end
        if (n >= max) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 + i;
        mem[12'h010] = 32'hA0;
        mem[12'h011] = 32'hA1;
        mem[12'h012] = 32'hA2;
        mem[12'h013] = 32'hA3;

        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Basic transfer, full rate: beats at start+2..start+5, done at start+6.
        do_start(12'h010, 13'd4);
        @(negedge sys_clk);
        chk("t1_busy_s1", busy, 1);
        chk("t1_valid_s1", bus.m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            chk("t1_valid", bus.m_valid, 1);
            chk("t1_data", bus.m_data, 32'hA0 + i);
            chk("t1_last", bus.m_last, (i == 3));
            chk("t1_busy", busy, 1);
        end
        @(negedge sys_clk);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", bus.m_valid, 0);
        @(negedge sys_clk);
        chk("t1_done_clr", done, 0);
        wait_idle(20);

        // Wrap across the top of the address space.
        do_start(12'hFFE, 13'd4);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("t2_b0", bus.m_data, 32'h5A00_0FFE);
        @(negedge sys_clk);
        chk("t2_b1", bus.m_data, 32'h5A00_0FFF);
        @(negedge sys_clk);
        chk("t2_b2", bus.m_data, 32'h5A00_0000);
        chk("t2_b2_last", bus.m_last, 0);
        @(negedge sys_clk);
        chk("t2_b3", bus.m_data, 32'h5A00_0001);
        chk("t2_b3_last", bus.m_last, 1);
        wait_idle(20);

        // Backpressure.
        pat_en = 1;
        do_start(12'h200, 13'd8);
        wait_idle(100);
        pat_en = 0;
        chk("t3_count", popped, 8);

        // Zero length: done next cycle, nothing else.
        do_start(12'h050, 13'd0);
        @(negedge sys_clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", bus.m_valid, 0);
        @(negedge sys_clk);
        chk("t4_done_clr", done, 0);
        chk("t4_valid2", bus.m_valid, 0);

        // Start while busy is ignored.
        do_start(12'h300, 13'd6);
        @(posedge sys_clk);
        #1;
        start     = 1'b1;
        base_addr = 12'h777;
        length    = 13'd3;
        @(posedge sys_clk);
        #1 start = 1'b0;
        wait_idle(40);
        chk("t5_count", popped, 6);
        chk("t5_base", cur_base, 12'h300);

        // Reset after three of six beats.
        do_start(12'h400, 13'd6);
        repeat (4) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", bus.m_valid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_done_rst", done, 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        do_start(12'h410, 13'd2);
        wait_idle(20);
        chk("t6_count", popped, 2);

        // Full depth with wrap.
        do_start(12'h123, 13'd4096);
        wait_idle(5000);
        chk("t7_count", popped, 4096);

        repeat (3) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
Single-clock read master for one port of the team's dual-port RAM (registered read, 1-cycle latency, no enable). It reads a contiguous, wrap-around address window and presents the words as a valid/ready stream with a last-beat marker. A 2-entry output buffer absorbs the RAM's read latency, so full throughput is sustained under backpressure without dropping words. It is the consumer-side counterpart of the RAM write path, for packet and descriptor readout.

Parameters:
ADDR_WIDTH, 12, RAM address width; must match the attached RAM.
DATA_WIDTH, 32, RAM data width.
LEN_WIDTH, 13, width of the transfer length; allows lengths up to the full RAM depth.

Ports:
sys_clk  in  1  clock; also drives the attached RAM port.
sys_rst_n  in  1  asynchronous reset, active-low.
start  in  1  one-cycle request; sampled only while busy=0.
base_addr  in  ADDR_WIDTH  first word address; sampled with start.
length  in  LEN_WIDTH  number of words to read; sampled with start.
busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
done  out  1  one-cycle pulse after the last beat is accepted downstream.
ram_addr  out  ADDR_WIDTH  to RAM addr port.
ram_we  out  1  to RAM we port; constant 0.
ram_dout  in  DATA_WIDTH  from RAM dout port.
m_data  out  DATA_WIDTH  stream data.
m_valid  out  1  stream valid.
m_last  out  1  marks the final beat of a transfer.
m_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_addr=0, ram_we=0; the output buffer is emptied.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 with length!=0 → latch base_addr and length into rd_addr and rd_remaining; set tx_remaining=length; go to READ.
  - start=1 with length=0 → pulse done on the next cycle; busy stays 0; no RAM access.
  - start while busy=1 is ignored.
- Read issue: a read is issued in a cycle when state=READ, rd_remaining>0 and (buffer occupancy + in-flight reads) < 2.
  - ram_addr=rd_addr is driven that cycle; rd_pending is set.
  - On issue, rd_addr increments modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000) and rd_remaining decrements.
- Capture: in the cycle after an issue (rd_pending=1), ram_dout is written into the buffer. Without rd_pending, ram_dout is ignored.
- Address hold: ram_addr holds its last value when no read is issued. A RAM read without capture has no side effects.
- Buffer: 2-entry FIFO; the head drives m_data and m_valid.
  - The head stays stable while m_valid=1 and m_ready=0.
  - A pop (m_valid & m_ready) and a capture may occur in the same cycle.
  - The credit rule guarantees the buffer never overflows.
- Last beat: m_last=1 on the head beat when tx_remaining=1. tx_remaining decrements on each pop.
- Transitions:
  - READ → DRAIN when rd_remaining reaches 0.
  - DRAIN → IDLE on the pop of the last beat; done pulses in the following cycle, and busy drops in that same cycle.
- Throughput: with m_ready held at 1, one beat per cycle. The first m_valid appears 2 cycles after the start cycle (latch, issue, capture); the last beat appears length+1 cycles after start.
- Length equal to full depth (4096) reads every word exactly once, with wrap.
- Reset mid-transfer: the transfer is aborted, with no done pulse and no further beats.

Test Plan:
- base=0x010, length=4, words preloaded 0xA0..0xA3, m_ready=1 → beats A0,A1,A2,A3 on consecutive cycles starting at start+2; m_last on A3; done 1 cycle after A3; busy high start+1..done.
- base=0xFFE, length=4 → reads addresses FFE, FFF, 000, 001, in order; m_last on the 4th beat.
- length=8, m_ready toggling 1,0,0,1,0,1... → all 8 words delivered in order, none duplicated or dropped; m_data stable while stalled; ram_addr never more than 2 words ahead of the last popped beat.
- start with length=0 → done pulse next cycle; m_valid never asserts; busy stays 0.
- Second start pulsed mid-transfer with a different base → ignored; first transfer completes unchanged.
- sys_rst_n asserted after 3 of 6 beats → m_valid, busy and done go to 0 immediately; after release, a new start with length=2 works normally.
